// File: rtl/parking_pkg.sv
// parking_pkg: shared lane state encoding and default timing constants for the gate controller
package parking_pkg;

    typedef enum logic [2:0] {IDLE, OPENING, WAIT_PASS, PASSING, CLOSING} lane_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int OPEN_CYCLES_DEF     = 20;
    localparam int CLOSE_CYCLES_DEF    = 20;
    localparam int PASS_TIMEOUT_DEF    = 200;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/parking_gate_lane.sv
// parking_gate_lane: loop conditioning, timer and barrier FSM for one lane
//   clk, rst_n          clock, async active-low reset
//   arm_raw, pass_raw   raw inductive loops before / after the barrier
//   blocked             refuse to start a new cycle while high
//   gate_up             barrier raise/hold command
//   pass_req            one-cycle request to count a car (PASSING -> CLOSING)
//   timeout             one-cycle pulse when WAIT_PASS gives up
//   refused             lane idle with a debounced car on ARM while blocked
module parking_gate_lane
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int OPEN_CYCLES     = OPEN_CYCLES_DEF,
    parameter int CLOSE_CYCLES    = CLOSE_CYCLES_DEF,
    parameter int PASS_TIMEOUT    = PASS_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm_raw,
    input  logic pass_raw,
    input  logic blocked,
    output logic gate_up,
    output logic pass_req,
    output logic timeout,
    output logic refused
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = $clog2(max3(OPEN_CYCLES, CLOSE_CYCLES, PASS_TIMEOUT) + 1);

    // bit 0 = ARM loop, bit 1 = PASS loop
    logic [1:0]          sync1_q, sync2_q, db_q, db_d, flip;
    logic [1:0][DBW-1:0] cnt_q, cnt_d;
    lane_state_e         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                arm, pass;

    always_comb begin
        flip  = '0;
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            flip[i]  = (sync2_q[i] != db_q[i]) && (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1));
            db_d[i]  = flip[i] ? sync2_q[i] : db_q[i];
            cnt_d[i] = (sync2_q[i] == db_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
        end
    end

    // The FSM acts on the level being accepted this clock, so the gate moves
    // on the same edge the debounced level changes.
    assign arm  = db_d[0];
    assign pass = db_d[1];

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pass_req = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: if (arm && !blocked) begin
                state_d = OPENING;
                timer_d = '0;
            end
            OPENING: begin
                state_d = (timer_q == TW'(OPEN_CYCLES - 1)) ? WAIT_PASS : OPENING;
                timer_d = (timer_q == TW'(OPEN_CYCLES - 1)) ? '0 : timer_q + 1'b1;
            end
            WAIT_PASS: if (pass) begin
                state_d = PASSING;
                timer_d = '0;
            end else if (timer_q != TW'(PASS_TIMEOUT)) begin
                timer_d = timer_q + 1'b1;
            end else if (!arm) begin
                state_d = CLOSING;
                timer_d = '0;
                timeout = 1'b1;
            end
            PASSING: if (!pass) begin
                state_d  = CLOSING;
                timer_d  = '0;
                pass_req = 1'b1;
            end
            CLOSING: if (arm || pass) begin
                state_d = OPENING;
                timer_d = '0;
            end else begin
                state_d = (timer_q == TW'(CLOSE_CYCLES - 1)) ? IDLE : CLOSING;
                timer_d = (timer_q == TW'(CLOSE_CYCLES - 1)) ? '0 : timer_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            sync1_q <= {pass_raw, arm_raw};
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign gate_up = (state_q == OPENING) || (state_q == WAIT_PASS) || (state_q == PASSING);
    assign refused = (state_q == IDLE) && db_q[0] && blocked;

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entry/exit barrier control with car count pulses
//   CLK, RESET_N                  clock, async active-low reset
//   ENTRY_ARM/PASS, EXIT_ARM/PASS raw loops of each lane
//   FULL                          car park full, blocks new entry cycles
//   ENTRY_sensor, EXIT_sensor     registered one-cycle count pulses, never together
//   ENTRY_GATE_UP, EXIT_GATE_UP   barrier commands
//   ENTRY_DENIED                  registered "car park full" lamp
//   ENTRY_TIMEOUT, EXIT_TIMEOUT   one-cycle pulses for aborted cycles
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int OPEN_CYCLES     = OPEN_CYCLES_DEF,
    parameter int CLOSE_CYCLES    = CLOSE_CYCLES_DEF,
    parameter int PASS_TIMEOUT    = PASS_TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic ENTRY_ARM,
    input  logic ENTRY_PASS,
    input  logic EXIT_ARM,
    input  logic EXIT_PASS,
    input  logic FULL,
    output logic ENTRY_sensor,
    output logic EXIT_sensor,
    output logic ENTRY_GATE_UP,
    output logic EXIT_GATE_UP,
    output logic ENTRY_DENIED,
    output logic ENTRY_TIMEOUT,
    output logic EXIT_TIMEOUT
);

    logic entry_req, exit_req, entry_refused, exit_refused;
    logic entry_sensor_q, entry_sensor_d, exit_sensor_q, exit_sensor_d;
    logic pending_q, pending_d, denied_q, denied_d;

    parking_gate_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .OPEN_CYCLES(OPEN_CYCLES),
        .CLOSE_CYCLES(CLOSE_CYCLES), .PASS_TIMEOUT(PASS_TIMEOUT)
    ) u_entry (
        .clk(CLK), .rst_n(RESET_N), .arm_raw(ENTRY_ARM), .pass_raw(ENTRY_PASS),
        .blocked(FULL), .gate_up(ENTRY_GATE_UP), .pass_req(entry_req),
        .timeout(ENTRY_TIMEOUT), .refused(entry_refused)
    );

    parking_gate_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .OPEN_CYCLES(OPEN_CYCLES),
        .CLOSE_CYCLES(CLOSE_CYCLES), .PASS_TIMEOUT(PASS_TIMEOUT)
    ) u_exit (
        .clk(CLK), .rst_n(RESET_N), .arm_raw(EXIT_ARM), .pass_raw(EXIT_PASS),
        .blocked(1'b0), .gate_up(EXIT_GATE_UP), .pass_req(exit_req),
        .timeout(EXIT_TIMEOUT), .refused(exit_refused)
    );

    // Exit wins a tie; the entry count is parked one cycle in pending_q.
    // CLOSE_CYCLES >= 2 guarantees the flag drains before another entry request.
    always_comb begin
        exit_sensor_d  = exit_req;
        entry_sensor_d = pending_q || (entry_req && !exit_req);
        pending_d      = entry_req && exit_req;
        // exit lane is never blocked, so only the entry lane can light the lamp
        denied_d       = entry_refused || exit_refused;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            entry_sensor_q <= 1'b0;
            exit_sensor_q  <= 1'b0;
            pending_q      <= 1'b0;
            denied_q       <= 1'b0;
        end else begin
            entry_sensor_q <= entry_sensor_d;
            exit_sensor_q  <= exit_sensor_d;
            pending_q      <= pending_d;
            denied_q       <= denied_d;
        end
    end

    assign ENTRY_sensor = entry_sensor_q;
    assign EXIT_sensor  = exit_sensor_q;
    assign ENTRY_DENIED = denied_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed scenario bench for the gate controller
module tb_parking_gate_controller;

    logic CLK = 1'b0, RESET_N = 1'b0;
    logic ENTRY_ARM = 1'b0, ENTRY_PASS = 1'b0, EXIT_ARM = 1'b0, EXIT_PASS = 1'b0, FULL = 1'b0;
    logic ENTRY_sensor, EXIT_sensor, ENTRY_GATE_UP, EXIT_GATE_UP, ENTRY_DENIED, ENTRY_TIMEOUT, EXIT_TIMEOUT;
    logic [6:0] outs;
    int n_pass = 0, n_total = 0;
    int n_entry = 0, n_exit = 0, n_both = 0, n_eto = 0, n_xto = 0, n_xgate = 0;
    int b0, b1, b2;

    parking_gate_controller dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENTRY_ARM(ENTRY_ARM), .ENTRY_PASS(ENTRY_PASS),
        .EXIT_ARM(EXIT_ARM), .EXIT_PASS(EXIT_PASS), .FULL(FULL),
        .ENTRY_sensor(ENTRY_sensor), .EXIT_sensor(EXIT_sensor),
        .ENTRY_GATE_UP(ENTRY_GATE_UP), .EXIT_GATE_UP(EXIT_GATE_UP),
        .ENTRY_DENIED(ENTRY_DENIED), .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .EXIT_TIMEOUT(EXIT_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    assign outs = {ENTRY_sensor, EXIT_sensor, ENTRY_GATE_UP, EXIT_GATE_UP, ENTRY_DENIED, ENTRY_TIMEOUT, EXIT_TIMEOUT};

    always @(posedge CLK) begin
        if (ENTRY_sensor) n_entry <= n_entry + 1;
        if (EXIT_sensor) n_exit <= n_exit + 1;
        if (ENTRY_sensor && EXIT_sensor) n_both <= n_both + 1;
        if (ENTRY_TIMEOUT) n_eto <= n_eto + 1;
        if (EXIT_TIMEOUT) n_xto <= n_xto + 1;
        if (EXIT_GATE_UP) n_xgate <= n_xgate + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        {ENTRY_ARM, ENTRY_PASS, EXIT_ARM, EXIT_PASS, FULL} = '0;
        step(2);
        RESET_N = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        step(2);
        n_total++; if (outs !== 7'b0) $display("FAIL reset_outs: got %b want 0000000", outs); else n_pass++;
        RESET_N = 1'b1;
        step(3);
        n_total++; if (outs !== 7'b0) $display("FAIL reset_idle: got %b want 0000000", outs); else n_pass++;
    endtask

    task automatic test_entry_happy();
        do_reset();
        b0 = n_entry; b1 = n_eto;
        ENTRY_ARM = 1'b1;
        step(5);
        n_total++; if (ENTRY_GATE_UP !== 1'b0) $display("FAIL happy_gate_early: got %b want 0", ENTRY_GATE_UP); else n_pass++;
        step(1);
        n_total++; if (ENTRY_GATE_UP !== 1'b1) $display("FAIL happy_gate_rise6: got %b want 1", ENTRY_GATE_UP); else n_pass++;
        step(4);
        ENTRY_ARM = 1'b0;
        step(26);
        ENTRY_PASS = 1'b1;
        step(10);
        ENTRY_PASS = 1'b0;
        step(5);
        n_total++; if ({ENTRY_sensor, ENTRY_GATE_UP} !== 2'b01) $display("FAIL happy_before_count: got %b want 01", {ENTRY_sensor, ENTRY_GATE_UP}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_sensor, ENTRY_GATE_UP} !== 2'b10) $display("FAIL happy_count_pulse: got %b want 10", {ENTRY_sensor, ENTRY_GATE_UP}); else n_pass++;
        step(1);
        n_total++; if (ENTRY_sensor !== 1'b0) $display("FAIL happy_pulse_width: got %b want 0", ENTRY_sensor); else n_pass++;
        // FULL distinguishes CLOSING (re-open) from IDLE (refuse) at the 20-clock boundary
        FULL = 1'b1;
        step(14);
        ENTRY_ARM = 1'b1;
        step(6);
        n_total++; if ({ENTRY_GATE_UP, ENTRY_DENIED} !== 2'b00) $display("FAIL happy_idle_after_close: got %b want 00", {ENTRY_GATE_UP, ENTRY_DENIED}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_GATE_UP, ENTRY_DENIED} !== 2'b01) $display("FAIL happy_denied_after_close: got %b want 01", {ENTRY_GATE_UP, ENTRY_DENIED}); else n_pass++;
        ENTRY_ARM = 1'b0;
        step(8);
        FULL = 1'b0;
        step(3);
        n_total++; if (n_entry - b0 !== 1) $display("FAIL happy_count_total: got %0d want 1", n_entry - b0); else n_pass++;
        n_total++; if (n_eto - b1 !== 0) $display("FAIL happy_no_timeout: got %0d want 0", n_eto - b1); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        FULL = 1'b1;
        ENTRY_ARM = 1'b1;
        step(6);
        n_total++; if ({ENTRY_GATE_UP, ENTRY_DENIED} !== 2'b00) $display("FAIL full_denied_latency: got %b want 00", {ENTRY_GATE_UP, ENTRY_DENIED}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_GATE_UP, ENTRY_DENIED} !== 2'b01) $display("FAIL full_denied: got %b want 01", {ENTRY_GATE_UP, ENTRY_DENIED}); else n_pass++;
        step(20);
        n_total++; if ({ENTRY_GATE_UP, ENTRY_DENIED} !== 2'b01) $display("FAIL full_hold: got %b want 01", {ENTRY_GATE_UP, ENTRY_DENIED}); else n_pass++;
        FULL = 1'b0;
        step(1);
        n_total++; if ({ENTRY_GATE_UP, ENTRY_DENIED} !== 2'b10) $display("FAIL full_release_open: got %b want 10", {ENTRY_GATE_UP, ENTRY_DENIED}); else n_pass++;
        FULL = 1'b1;
        step(10);
        n_total++; if (ENTRY_GATE_UP !== 1'b1) $display("FAIL full_rise_during_open: got %b want 1", ENTRY_GATE_UP); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        b0 = n_entry; b1 = n_eto;
        ENTRY_ARM = 1'b1;
        step(10);
        ENTRY_ARM = 1'b0;
        step(215);
        n_total++; if ({ENTRY_TIMEOUT, ENTRY_GATE_UP} !== 2'b01) $display("FAIL timeout_early: got %b want 01", {ENTRY_TIMEOUT, ENTRY_GATE_UP}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_TIMEOUT, ENTRY_GATE_UP} !== 2'b11) $display("FAIL timeout_pulse: got %b want 11", {ENTRY_TIMEOUT, ENTRY_GATE_UP}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_TIMEOUT, ENTRY_GATE_UP} !== 2'b00) $display("FAIL timeout_close: got %b want 00", {ENTRY_TIMEOUT, ENTRY_GATE_UP}); else n_pass++;
        step(25);
        n_total++; if (n_eto - b1 !== 1) $display("FAIL timeout_count: got %0d want 1", n_eto - b1); else n_pass++;
        n_total++; if (n_entry - b0 !== 0) $display("FAIL timeout_no_sensor: got %0d want 0", n_entry - b0); else n_pass++;
    endtask

    task automatic test_glitch();
        do_reset();
        b0 = n_xgate;
        EXIT_ARM = 1'b1;
        step(3);
        EXIT_ARM = 1'b0;
        step(20);
        n_total++; if (n_xgate - b0 !== 0) $display("FAIL glitch_exit_gate: got %0d cycles up want 0", n_xgate - b0); else n_pass++;
        b0 = n_entry;
        ENTRY_ARM = 1'b1;
        step(10);
        ENTRY_ARM = 1'b0;
        step(20);
        ENTRY_PASS = 1'b1;
        step(10);
        ENTRY_PASS = 1'b0;
        step(2);
        ENTRY_PASS = 1'b1;
        step(10);
        n_total++; if ({n_entry - b0 == 0, ENTRY_GATE_UP} !== 2'b11) $display("FAIL glitch_pass_early: got count %0d gate %b want 0 1", n_entry - b0, ENTRY_GATE_UP); else n_pass++;
        ENTRY_PASS = 1'b0;
        step(6);
        n_total++; if (ENTRY_sensor !== 1'b1) $display("FAIL glitch_pass_count: got %b want 1", ENTRY_sensor); else n_pass++;
        step(2);
        n_total++; if (n_entry - b0 !== 1) $display("FAIL glitch_pass_total: got %0d want 1", n_entry - b0); else n_pass++;
    endtask

    task automatic test_reopen();
        do_reset();
        b0 = n_entry;
        ENTRY_ARM = 1'b1;
        step(10);
        ENTRY_ARM = 1'b0;
        step(20);
        ENTRY_PASS = 1'b1;
        step(10);
        ENTRY_PASS = 1'b0;
        step(5);
        ENTRY_ARM = 1'b1;
        step(1);
        n_total++; if ({ENTRY_sensor, ENTRY_GATE_UP} !== 2'b10) $display("FAIL reopen_closing: got %b want 10", {ENTRY_sensor, ENTRY_GATE_UP}); else n_pass++;
        step(4);
        n_total++; if (ENTRY_GATE_UP !== 1'b0) $display("FAIL reopen_early: got %b want 0", ENTRY_GATE_UP); else n_pass++;
        step(1);
        n_total++; if (ENTRY_GATE_UP !== 1'b1) $display("FAIL reopen_gate: got %b want 1", ENTRY_GATE_UP); else n_pass++;
        ENTRY_ARM = 1'b0;
        step(10);
        n_total++; if ({n_entry - b0 == 1, ENTRY_GATE_UP} !== 2'b11) $display("FAIL reopen_no_extra: got count %0d gate %b want 1 1", n_entry - b0, ENTRY_GATE_UP); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        b0 = n_entry; b1 = n_exit; b2 = n_both;
        {ENTRY_ARM, EXIT_ARM} = 2'b11;
        step(10);
        {ENTRY_ARM, EXIT_ARM} = 2'b00;
        step(20);
        {ENTRY_PASS, EXIT_PASS} = 2'b11;
        step(10);
        {ENTRY_PASS, EXIT_PASS} = 2'b00;
        step(5);
        n_total++; if ({ENTRY_sensor, EXIT_sensor} !== 2'b00) $display("FAIL coinc_before: got %b want 00", {ENTRY_sensor, EXIT_sensor}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_sensor, EXIT_sensor} !== 2'b01) $display("FAIL coinc_exit_first: got %b want 01", {ENTRY_sensor, EXIT_sensor}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_sensor, EXIT_sensor} !== 2'b10) $display("FAIL coinc_entry_deferred: got %b want 10", {ENTRY_sensor, EXIT_sensor}); else n_pass++;
        step(1);
        n_total++; if ({ENTRY_sensor, EXIT_sensor} !== 2'b00) $display("FAIL coinc_after: got %b want 00", {ENTRY_sensor, EXIT_sensor}); else n_pass++;
        step(2);
        n_total++; if ({n_entry - b0, n_exit - b1, n_both - b2} !== {32'sd1, 32'sd1, 32'sd0}) $display("FAIL coinc_counts: got %0d %0d %0d want 1 1 0", n_entry - b0, n_exit - b1, n_both - b2); else n_pass++;
    endtask

    task automatic test_reset_mid_cycle();
        do_reset();
        b2 = n_eto + n_xto;
        {ENTRY_ARM, EXIT_ARM} = 2'b11;
        step(240);
        n_total++; if ({ENTRY_GATE_UP, EXIT_GATE_UP} !== 2'b11) $display("FAIL hold_wait_pass: got %b want 11", {ENTRY_GATE_UP, EXIT_GATE_UP}); else n_pass++;
        n_total++; if (n_eto + n_xto - b2 !== 0) $display("FAIL hold_no_timeout: got %0d want 0", n_eto + n_xto - b2); else n_pass++;
        RESET_N = 1'b0;
        #1;
        n_total++; if (outs !== 7'b0) $display("FAIL reset_async: got %b want 0000000", outs); else n_pass++;
        {ENTRY_ARM, EXIT_ARM} = 2'b00;
        step(3);
        RESET_N = 1'b1;
        b0 = n_entry; b1 = n_exit;
        step(30);
        n_total++; if ({n_entry - b0 == 0, n_exit - b1 == 0, outs == 7'b0} !== 3'b111) $display("FAIL reset_no_pulse: got entry %0d exit %0d outs %b want 0 0 0000000", n_entry - b0, n_exit - b1, outs); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_entry_happy();
        test_full();
        test_timeout();
        test_glitch();
        test_reopen();
        test_back_to_back();
        test_reset_mid_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
